// File: rtl/keypad_pkg.sv
// keypad_pkg -- shared types and constants for the 4x4 keypad scanner.
//   state_t        : scanner FSM encoding (also exposed on the debug port)
//   KEY_W          : width of the encoded key code {row_idx, col_idx}
//   ROW_IDLE       : row strobe pattern after reset (row 0 driven low)
//   DEF_*          : default divider / debounce settings for a 25 MHz board clock
//   col_encode()   : lowest-index active-low column to a 2-bit index
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  localparam int KEY_W = 4;
  localparam logic [3:0] ROW_IDLE = 4'b1110;

  localparam int DEF_SCAN_DIV     = 25000;
  localparam int DEF_DEBOUNCE_CNT = 10;

  // Several columns down at once is legal: the lowest index wins.
  function automatic logic [1:0] col_encode(input logic [3:0] cols);
    if (!cols[0])      col_encode = 2'd0;
    else if (!cols[1]) col_encode = 2'd1;
    else if (!cols[2]) col_encode = 2'd2;
    else               col_encode = 2'd3;
  endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// scan_tick_gen -- enable-pulse divider; also intended for the display refresh.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   tick  : one-clk enable pulse every DIV clocks (never used as a clock)
// Parameter DIV (>= 2): clk cycles per tick period.
module scan_tick_gen #(
  parameter int DIV = 25000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Counter runs 0..DIV-1; the pulse marks the wrap cycle.
  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan -- 4x4 matrix keypad scanner with debounce and a one-deep
// key holding register toward the time-setting logic.
//   clk       : system clock (same board clock as the display refresh)
//   rst_n     : asynchronous active-low reset
//   row_out   : active-low one-cold row strobes
//   col_in    : active-low column returns (pulled up, asynchronous)
//   key_code  : {row_idx, col_idx} of the last accepted key
//   key_valid : key_code holds an unconsumed key
//   key_ack   : consumer accept
//   key_held  : a debounced key is currently down
//   overrun   : sticky, a key was dropped because key_valid was pending
//   dbg_state : current scanner FSM state (state_t encoding)
// Optional feature macro: KEYPAD_TYPEMATIC_EN adds auto-repeat while a key
// stays pressed (REPEAT_DELAY ticks to the first repeat, then REPEAT_RATE).
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = DEF_SCAN_DIV,
`ifdef KEYPAD_TYPEMATIC_EN
  parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
`else
  parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [3:0]       row_out,
  input  logic [3:0]       col_in,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ack,
  output logic             key_held,
  output logic             overrun,
  output logic [1:0]       dbg_state
);

  localparam int DW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CNT);

  logic             tick;
  logic [3:0]       col_m;
  logic [3:0]       col_s;
  logic             col_hit;
  logic [1:0]       col_idx;
  state_t           state;
  logic [1:0]       row_ptr;
  logic [1:0]       lat_col;
  logic [DW-1:0]    deb_cnt;
  logic [DW-1:0]    deb_nxt;
  logic             do_emit;
  logic [KEY_W-1:0] emit_code;

`ifdef KEYPAD_TYPEMATIC_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  logic [RW-1:0] rep_cnt;
  logic [RW-1:0] rep_nxt;
  logic [RW-1:0] rep_target;
  logic          rep_phase;   // 0: waiting for first repeat, 1: steady rate

  assign rep_nxt    = rep_cnt + RW'(1);
  assign rep_target = rep_phase ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);
`endif

  scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Two-flop synchronizer; idle columns read high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_m <= 4'hF;
      col_s <= 4'hF;
    end else begin
      col_m <= col_in;
      col_s <= col_m;
    end
  end

  assign col_hit   = (col_s != 4'hF);
  assign col_idx   = col_encode(col_s);
  assign deb_nxt   = deb_cnt + DW'(1);
  assign dbg_state = state;

  // Key emission request for this cycle; only ever raised on a tick.
  always_comb begin
    do_emit   = 1'b0;
    emit_code = {row_ptr, lat_col};
    if (tick) begin
      case (state)
        ST_SCAN: begin
          emit_code = {row_ptr, col_idx};
          if (col_hit && (DEB_LAST <= DW'(1))) do_emit = 1'b1;
        end
        ST_DEBOUNCE: begin
          if (col_hit && (col_idx == lat_col) && (deb_nxt == DEB_LAST)) do_emit = 1'b1;
        end
`ifdef KEYPAD_TYPEMATIC_EN
        ST_PRESSED: begin
          if (col_hit && (rep_nxt == rep_target)) do_emit = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  // Handshake: key_valid rises when a key is loaded and stays high until a
  // posedge sees key_valid && key_ack. An emit in the same cycle as that ack
  // reloads the register (valid stays high); an emit while valid is pending
  // without ack is dropped and sets the sticky overrun, cleared by the ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_out   <= ROW_IDLE;
      row_ptr   <= 2'd0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      overrun   <= 1'b0;
      state     <= ST_SCAN;
      lat_col   <= 2'd0;
      deb_cnt   <= '0;
`ifdef KEYPAD_TYPEMATIC_EN
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
`endif
    end else begin
      if (do_emit) begin
        if (!key_valid || key_ack) begin
          key_code  <= emit_code;
          key_valid <= 1'b1;
          overrun   <= 1'b0;
        end else begin
          overrun   <= 1'b1;
        end
      end else if (key_valid && key_ack) begin
        key_valid <= 1'b0;
        overrun   <= 1'b0;
      end

      if (tick) begin
        case (state)
          ST_SCAN: begin
            if (col_hit) begin
              lat_col <= col_idx;
              deb_cnt <= DW'(1);
              if (DEB_LAST <= DW'(1)) begin
                key_held <= 1'b1;
                state    <= ST_PRESSED;
              end else begin
                state    <= ST_DEBOUNCE;
              end
            end else begin
              row_out <= {row_out[2:0], row_out[3]};
              row_ptr <= row_ptr + 2'd1;
            end
          end
          ST_DEBOUNCE: begin
            if (col_hit && (col_idx == lat_col)) begin
              deb_cnt <= deb_nxt;
              if (deb_nxt == DEB_LAST) begin
                key_held <= 1'b1;
                state    <= ST_PRESSED;
              end
            end else begin
              // Bounce: rescan the same row next tick.
              deb_cnt <= '0;
              state   <= ST_SCAN;
            end
          end
          ST_PRESSED: begin
            if (!col_hit) begin
`ifdef KEYPAD_TYPEMATIC_EN
              rep_cnt   <= '0;
              rep_phase <= 1'b0;
`endif
              if (DEB_LAST <= DW'(1)) begin
                deb_cnt  <= '0;
                key_held <= 1'b0;
                row_out  <= {row_out[2:0], row_out[3]};
                row_ptr  <= row_ptr + 2'd1;
                state    <= ST_SCAN;
              end else begin
                deb_cnt  <= DW'(1);
                state    <= ST_RELEASE;
              end
            end else begin
`ifdef KEYPAD_TYPEMATIC_EN
              if (rep_nxt == rep_target) begin
                rep_cnt   <= '0;
                rep_phase <= 1'b1;
              end else begin
                rep_cnt   <= rep_nxt;
              end
`endif
            end
          end
          ST_RELEASE: begin
            if (!col_hit) begin
              if (deb_nxt == DEB_LAST) begin
                deb_cnt  <= '0;
                key_held <= 1'b0;
                row_out  <= {row_out[2:0], row_out[3]};
                row_ptr  <= row_ptr + 2'd1;
                state    <= ST_SCAN;
              end else begin
                deb_cnt  <= deb_nxt;
              end
            end else begin
              deb_cnt <= '0;
              state   <= ST_PRESSED;
            end
          end
          default: state <= ST_SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan -- directed bench for keypad_scan with SCAN_DIV=4,
// DEBOUNCE_CNT=3 (REPEAT_DELAY=6, REPEAT_RATE=2 when KEYPAD_TYPEMATIC_EN).
// A keypad model closes a row/column contact for the selected key; expected
// key codes go into exp_q and a monitor pops them as the DUT presents keys.
module tb_keypad_scan;
  import keypad_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_out;
  logic [3:0] col_in;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack = 1'b0;
  logic       key_held;
  logic       overrun;
  logic [1:0] dbg_state;

  logic       key_down = 1'b0;
  logic [3:0] key_num = 4'h0;
  logic       bounce_en = 1'b0;
  logic [3:0] bounce_val = 4'hF;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [3:0] exp_q[$];
  logic       prev_valid = 1'b0;
  logic [3:0] prev_code = 4'h0;

  keypad_scan #(
    .SCAN_DIV(4),
`ifdef KEYPAD_TYPEMATIC_EN
    .DEBOUNCE_CNT(3),
    .REPEAT_DELAY(6),
    .REPEAT_RATE(2)
`else
    .DEBOUNCE_CNT(3)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_out   (row_out),
    .col_in    (col_in),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .key_held  (key_held),
    .overrun   (overrun),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- keypad contact model ----------------
  always_comb begin
    col_in = 4'hF;
    if (bounce_en) begin
      col_in = bounce_val;
    end else if (key_down && !row_out[key_num[3:2]]) begin
      col_in[key_num[1:0]] = 1'b0;
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [3:0] e;
    if (rst_n && key_valid && (!prev_valid || key_code != prev_code)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL emit: unexpected key_code=%h with no expected key", key_code);
      end else begin
        e = exp_q.pop_front();
        if (key_code !== e) begin
          n_fail++;
          $display("FAIL emit: key_code=%h expected %h", key_code, e);
        end
      end
    end
    prev_valid = key_valid;
    prev_code  = key_code;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] probe(input int which);
    case (which)
      0:       probe = row_out;
      1:       probe = {3'b000, key_valid};
      2:       probe = {3'b000, key_held};
      3:       probe = {3'b000, overrun};
      4:       probe = {2'b00, dbg_state};
      default: probe = key_code;
    endcase
  endfunction

  // Poll at negedges until the probed signal equals val or the budget runs out.
  task automatic wait_sig(input string name, input int which, input logic [3:0] val,
                          input int budget);
    int n = 0;
    while (probe(which) !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (probe(which) !== val) begin
      n_fail++;
      $display("FAIL %s: timeout after %0d cycles, got %0h expected %0h",
               name, budget, probe(which), val);
    end
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    @(posedge clk);
    #1 key_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] k);
    key_num  = k;
    key_down = 1'b1;
  endtask

  task automatic release_key();
    key_down = 1'b0;
    wait_sig("release_held", 2, 4'h0, 200);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_row_out"},   row_out,   4'b1110);
    check({tag, "_key_code"},  key_code,  4'h0);
    check({tag, "_key_valid"}, key_valid, 1'b0);
    check({tag, "_key_held"},  key_held,  1'b0);
    check({tag, "_overrun"},   overrun,   1'b0);
    check({tag, "_state"},     dbg_state, ST_SCAN);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [3:0] rot_tbl[4];
    logic [3:0] r;
    logic       seen;
    int         t[4];

    rot_tbl[0] = 4'b1101; rot_tbl[1] = 4'b1011;
    rot_tbl[2] = 4'b0111; rot_tbl[3] = 4'b1110;

    // Reset values.
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Idle scanning rotates the row strobe.
    for (int i = 0; i < 4; i++) wait_sig("rotate", 0, rot_tbl[i], 20);

    // Key 6 (row 1, col 2): emitted once, row frozen.
    exp_q.push_back(4'h6);
    press(4'h6);
    wait_sig("press6_valid", 1, 4'h1, 200);
    check("press6_held", key_held, 1'b1);
    check("press6_row", row_out, 4'b1101);
    check("press6_state", dbg_state, ST_PRESSED);
    repeat (20) @(negedge clk);
    check("press6_still_valid", key_valid, 1'b1);
    check("press6_row_frozen", row_out, 4'b1101);

    // Overrun: key F while 6 still pending.
    release_key();
    press(4'hF);
    wait_sig("overrun_set", 3, 4'h1, 300);
    check("overrun_code_kept", key_code, 4'h6);
    check("overrun_valid", key_valid, 1'b1);
    check("overrun_held", key_held, 1'b1);
    ack_pulse();
    check("ack_valid_clr", key_valid, 1'b0);
    check("ack_overrun_clr", overrun, 1'b0);
    release_key();

    // Ack on the exact emit cycle of key 9 while 6 is pending.
    exp_q.push_back(4'h6);
    press(4'h6);
    wait_sig("repress6_valid", 1, 4'h1, 300);
    release_key();
    exp_q.push_back(4'h9);
    press(4'h9);
    wait_sig("key9_debounce", 4, {2'b00, ST_DEBOUNCE}, 300);
    repeat (7) @(posedge clk);
    #1 key_ack = 1'b1;
    @(posedge clk);
    #1 key_ack = 1'b0;
    @(negedge clk);
    check("simul_valid", key_valid, 1'b1);
    check("simul_code", key_code, 4'h9);
    check("simul_overrun", overrun, 1'b0);
    check("simul_held", key_held, 1'b1);
    release_key();

    // Reset in DEBOUNCE with key 9 still pending.
    press(4'h5);
    wait_sig("key5_debounce", 4, {2'b00, ST_DEBOUNCE}, 300);
    check("pre_reset_row", row_out, 4'b1101);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    key_down = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_sig("restart_rotate", 0, 4'b1101, 20);
    check("restart_valid", key_valid, 1'b0);

    // Bounce on row 1: alternate hit/no-hit each tick, never emits.
    wait_sig("bounce_row", 0, 4'b1101, 20);
    seen = 1'b0;
    bounce_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bounce_val = (i % 2 == 0) ? 4'b1011 : 4'b1111;
      repeat (4) begin
        @(negedge clk);
        if (key_valid) seen = 1'b1;
      end
    end
    bounce_en = 1'b0;
    bounce_val = 4'hF;
    check("bounce_no_valid", seen, 1'b0);
    wait_sig("bounce_scan", 4, {2'b00, ST_SCAN}, 20);
    r = row_out;
    wait_sig("bounce_rotate", 0, {r[2:0], r[3]}, 20);

`ifdef KEYPAD_TYPEMATIC_EN
    // Auto-repeat: emits at debounce, +6 ticks, then every 2 ticks (4 clk/tick).
    for (int i = 0; i < 4; i++) exp_q.push_back(4'h3);
    press(4'h3);
    for (int i = 0; i < 4; i++) begin
      wait_sig("repeat_valid", 1, 4'h1, 200);
      t[i] = cyc;
      if (i == 3) key_down = 1'b0;
      ack_pulse();
    end
    check("repeat_first_gap", t[1] - t[0], 24);
    check("repeat_gap2", t[2] - t[1], 8);
    check("repeat_gap3", t[3] - t[2], 8);
    wait_sig("repeat_release", 2, 4'h0, 200);
    check("repeat_no_extra", key_valid, 1'b0);
`else
    // Without auto-repeat a long hold gives exactly one key.
    exp_q.push_back(4'h3);
    press(4'h3);
    wait_sig("single_valid", 1, 4'h1, 200);
    t[0] = cyc;
    ack_pulse();
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (key_valid) seen = 1'b1;
    end
    check("single_no_repeat", seen, 1'b0);
    check("single_held", key_held, 1'b1);
    release_key();
`endif

    repeat (4) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
